// File: rtl/pipe_stage_reg_if.sv
// Bundle of stall/flush control, upstream payload and scratch, and the registered
// stage outputs. Control and upstream inputs are driven by the master side.
interface pipe_stage_reg_if #(
    parameter int PAYLOAD_W = 103,
    parameter int TEMP_W    = 64,
    parameter int CNT_W     = 2,
    parameter int BCNT_W    = 16
);
    logic [5:0]           stall;
    logic                 flush;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [TEMP_W-1:0]    in_temp;
    logic [CNT_W-1:0]     in_cnt;
    logic                 bcnt_clr;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [TEMP_W-1:0]    out_temp;
    logic [CNT_W-1:0]     out_cnt;
    logic [BCNT_W-1:0]    out_bcnt;

    modport master (
        output stall, flush, in_payload, in_temp, in_cnt, bcnt_clr,
        input  out_payload, out_temp, out_cnt, out_bcnt
    );

    modport slave (
        input  stall, flush, in_payload, in_temp, in_cnt, bcnt_clr,
        output out_payload, out_temp, out_cnt, out_bcnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline register between two stages: advances, holds or inserts a bubble from
// the stall vector, feeds multi-cycle scratch back upstream and counts bubbles.
module pipe_stage_reg #(
    parameter int                   PAYLOAD_W = 103,
    parameter int                   STAGE     = 3,
    parameter logic [PAYLOAD_W-1:0] NOP_VAL   = '0,
    parameter int                   TEMP_W    = 64,
    parameter int                   CNT_W     = 2,
    parameter int                   BCNT_W    = 16
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_reg_if.slave bus
);
    if (STAGE < 0 || STAGE > 4) begin : g_bad_stage
        $fatal(1, "pipe_stage_reg: STAGE=%0d outside 0..4", STAGE);
    end

    // Handshake: stall bit 1 means Stop. The upstream stage is stall[STAGE], the
    // downstream stage is stall[STAGE+1]; there is no valid/ready pair here.
    logic w_up;
    logic w_dn;
    logic w_bubble;

    assign w_up     = bus.stall[STAGE];
    assign w_dn     = bus.stall[STAGE+1];
    assign w_bubble = !bus.flush && w_up && !w_dn;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_payload <= NOP_VAL;
            bus.out_temp    <= '0;
            bus.out_cnt     <= '0;
            bus.out_bcnt    <= '0;
        end else begin
            if (bus.flush) begin
                bus.out_payload <= NOP_VAL;
                bus.out_temp    <= '0;
                bus.out_cnt     <= '0;
            end else if (w_bubble) begin
                bus.out_payload <= NOP_VAL;
                bus.out_temp    <= bus.in_temp;
                bus.out_cnt     <= bus.in_cnt;
            end else if (!w_up) begin
                bus.out_payload <= bus.in_payload;
                bus.out_temp    <= '0;
                bus.out_cnt     <= '0;
            end else begin
                // Hold: payload frozen, scratch keeps following the upstream stage.
                bus.out_temp    <= bus.in_temp;
                bus.out_cnt     <= bus.in_cnt;
            end

            if (bus.bcnt_clr) begin
                bus.out_bcnt <= '0;
            end else if (w_bubble && (bus.out_bcnt != '1)) begin
                bus.out_bcnt <= bus.out_bcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance and a 2-bit bubble-counter
// instance share stimulus and are compared against a rule-level model every cycle.
module tb_pipe_stage_reg;
    localparam int PW = 103;
    localparam int TW = 64;
    localparam int CW = 2;

    logic clk;
    logic rst;

    pipe_stage_reg_if #(.PAYLOAD_W(PW), .TEMP_W(TW), .CNT_W(CW), .BCNT_W(16)) ifa ();
    pipe_stage_reg_if #(.PAYLOAD_W(PW), .TEMP_W(TW), .CNT_W(CW), .BCNT_W(2))  ifb ();

    pipe_stage_reg #(.PAYLOAD_W(PW), .STAGE(3), .TEMP_W(TW), .CNT_W(CW), .BCNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    pipe_stage_reg #(.PAYLOAD_W(PW), .STAGE(3), .TEMP_W(TW), .CNT_W(CW), .BCNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    assign ifb.stall      = ifa.stall;
    assign ifb.flush      = ifa.flush;
    assign ifb.in_payload = ifa.in_payload;
    assign ifb.in_temp    = ifa.in_temp;
    assign ifb.in_cnt     = ifa.in_cnt;
    assign ifb.bcnt_clr   = ifa.bcnt_clr;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: stage action decided from the stall rules for STAGE=3
    logic [PW-1:0] m_payload;
    logic [TW-1:0] m_temp;
    logic [CW-1:0] m_cnt;
    int            m_bcnt_a;
    int            m_bcnt_b;
    bit            m_valid = 1'b0;

    always @(posedge clk) begin
        string act;
        if (rst) act = "reset";
        else if (ifa.flush) act = "flush";
        else if (ifa.stall[3] && !ifa.stall[4]) act = "bubble";
        else if (!ifa.stall[3]) act = "advance";
        else act = "hold";

        case (act)
            "reset": begin
                m_payload = '0; m_temp = '0; m_cnt = '0; m_bcnt_a = 0; m_bcnt_b = 0;
                m_valid = 1'b1;
            end
            "flush":   begin m_payload = '0; m_temp = '0; m_cnt = '0; end
            "bubble":  begin m_payload = '0; m_temp = ifa.in_temp; m_cnt = ifa.in_cnt; end
            "advance": begin m_payload = ifa.in_payload; m_temp = '0; m_cnt = '0; end
            default:   begin m_temp = ifa.in_temp; m_cnt = ifa.in_cnt; end
        endcase

        if (act != "reset") begin
            if (ifa.bcnt_clr) begin
                m_bcnt_a = 0;
                m_bcnt_b = 0;
            end else if (act == "bubble") begin
                m_bcnt_a = (m_bcnt_a == 65535) ? 65535 : m_bcnt_a + 1;
                m_bcnt_b = (m_bcnt_b == 3) ? 3 : m_bcnt_b + 1;
            end
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_payload", 128'(ifa.out_payload), 128'(m_payload));
            check("cmp_temp",    128'(ifa.out_temp),    128'(m_temp));
            check("cmp_cnt",     128'(ifa.out_cnt),     128'(m_cnt));
            check("cmp_bcnt_a",  128'(ifa.out_bcnt),    128'(m_bcnt_a));
            check("cmp_bcnt_b",  128'(ifb.out_bcnt),    128'(m_bcnt_b));
            check("cmp_b_payload", 128'(ifb.out_payload), 128'(m_payload));
        end
    end

    // driver
    task automatic drive(input logic r, input logic [5:0] st, input logic fl,
                         input logic [PW-1:0] p, input logic [TW-1:0] t,
                         input logic [CW-1:0] c, input logic clr);
        rst            = r;
        ifa.stall      = st;
        ifa.flush      = fl;
        ifa.in_payload = p;
        ifa.in_temp    = t;
        ifa.in_cnt     = c;
        ifa.bcnt_clr   = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [PW-1:0] P1 = 103'h1_2345_6789_ABCD_EF01_2345_6789;
    localparam logic [PW-1:0] P2 = 103'h55_AAAA_5555_0F0F_F0F0_1234_5678;
    localparam logic [PW-1:0] P3 = 103'h7F_0000_0000_DEAD_BEEF_0000_0001;
    localparam logic [TW-1:0] T1 = 64'h0000_0001_0000_0002;

    int exp_b[5] = '{1, 2, 3, 3, 3};

    initial begin
        drive(1'b1, 6'b111111, 1'b1, P3, 64'hFFFF, 2'd3, 1'b1);
        tick();
        check("reset_payload", 128'(ifa.out_payload), 128'd0);
        check("reset_temp",    128'(ifa.out_temp),    128'd0);
        check("reset_cnt",     128'(ifa.out_cnt),     128'd0);
        check("reset_bcnt",    128'(ifa.out_bcnt),    128'd0);

        // advance
        drive(1'b0, 6'b000000, 1'b0, P1, 64'hFF, 2'd2, 1'b0);
        tick();
        check("adv_payload", 128'(ifa.out_payload), 128'(P1));
        check("adv_temp",    128'(ifa.out_temp),    128'd0);
        check("adv_cnt",     128'(ifa.out_cnt),     128'd0);

        // bubble
        drive(1'b0, 6'b001111, 1'b0, P2, T1, 2'd1, 1'b0);
        tick();
        check("bub_payload", 128'(ifa.out_payload), 128'd0);
        check("bub_temp",    128'(ifa.out_temp),    128'h0000_0001_0000_0002);
        check("bub_cnt",     128'(ifa.out_cnt),     128'd1);
        check("bub_bcnt",    128'(ifa.out_bcnt),    128'd1);

        // load P2 then hold for three edges
        drive(1'b0, 6'b000000, 1'b0, P2, 64'h0, 2'd0, 1'b0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 6'b011111, 1'b0, P3, 64'h100 + 64'(i), 2'(i), 1'b0);
            tick();
            check("hold_payload", 128'(ifa.out_payload), 128'(P2));
            check("hold_cnt",     128'(ifa.out_cnt),     128'(i));
            check("hold_bcnt",    128'(ifa.out_bcnt),    128'd1);
        end

        // flush beats a bubble
        drive(1'b0, 6'b001111, 1'b1, P1, T1, 2'd3, 1'b0);
        tick();
        check("flush_payload", 128'(ifa.out_payload), 128'd0);
        check("flush_temp",    128'(ifa.out_temp),    128'd0);
        check("flush_cnt",     128'(ifa.out_cnt),     128'd0);
        check("flush_bcnt",    128'(ifa.out_bcnt),    128'd1);

        // clear, then five bubbles into the 2-bit counter
        drive(1'b0, 6'b000000, 1'b0, P1, 64'h0, 2'd0, 1'b1);
        tick();
        check("clr_bcnt", 128'(ifb.out_bcnt), 128'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 6'b001111, 1'b0, P1, 64'(i), 2'(i), 1'b0);
            tick();
            check("sat_bcnt_b", 128'(ifb.out_bcnt), 128'(exp_b[i]));
            check("sat_bcnt_a", 128'(ifa.out_bcnt), 128'(i + 1));
        end
        drive(1'b0, 6'b001111, 1'b0, P1, 64'h9, 2'd1, 1'b1);
        tick();
        check("clr_bub_bcnt_a", 128'(ifa.out_bcnt), 128'd0);
        check("clr_bub_bcnt_b", 128'(ifb.out_bcnt), 128'd0);
        check("clr_bub_temp",   128'(ifa.out_temp), 128'h9);

        // reset in the middle of a hold
        drive(1'b0, 6'b000000, 1'b0, P1, 64'h0, 2'd0, 1'b0);
        tick();
        drive(1'b0, 6'b011111, 1'b0, P2, 64'hDEAD, 2'd2, 1'b0);
        tick();
        check("mid_temp", 128'(ifa.out_temp), 128'hDEAD);
        drive(1'b1, 6'b011111, 1'b0, P2, 64'hDEAD, 2'd3, 1'b0);
        tick();
        check("mid_rst_payload", 128'(ifa.out_payload), 128'd0);
        check("mid_rst_temp",    128'(ifa.out_temp),    128'd0);
        check("mid_rst_cnt",     128'(ifa.out_cnt),     128'd0);
        drive(1'b0, 6'b000000, 1'b0, P3, 64'h5, 2'd1, 1'b0);
        tick();
        check("post_rst_payload", 128'(ifa.out_payload), 128'(P3));
        check("post_rst_temp",    128'(ifa.out_temp),    128'd0);

        tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The module SHALL provide the parameter PAYLOAD_W, default 103, giving the stage payload width (wd 5, wreg 1, wdata 32, hi 32, lo 32, whilo 1).
REQ-002 The module SHALL provide the parameter STAGE, default 3, giving the stall-vector index of the upstream stage; legal range 0..4.
REQ-003 The module SHALL provide the parameter NOP_VAL, default all-zeros PAYLOAD_W bits, giving the bubble payload.
REQ-004 The module SHALL provide the parameter TEMP_W, default 64, giving the multi-cycle scratch width.
REQ-005 The module SHALL provide the parameter CNT_W, default 2, giving the multi-cycle step-counter width.
REQ-006 The module SHALL provide the parameter BCNT_W, default 16, giving the bubble-counter width.
REQ-007 The module SHALL provide the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-008 The module SHALL provide the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The module SHALL provide the port stall, input, 6 bits: pipeline stall vector from the control unit, Stop=1.
REQ-010 The module SHALL provide the port flush, input, 1 bit: exception flush request.
REQ-011 The module SHALL provide the port in_payload, input, PAYLOAD_W bits: payload from the upstream stage.
REQ-012 The module SHALL provide the ports in_temp (input, TEMP_W bits) and in_cnt (input, CNT_W bits): multi-cycle scratch and step count from the upstream stage.
REQ-013 The module SHALL provide the port bcnt_clr, input, 1 bit: clears the bubble counter.
REQ-014 The module SHALL provide the port out_payload, output reg, PAYLOAD_W bits: payload to the downstream stage.
REQ-015 The module SHALL provide the ports out_temp (output reg, TEMP_W bits) and out_cnt (output reg, CNT_W bits): scratch and step count fed back to the upstream stage.
REQ-016 The module SHALL provide the port out_bcnt, output reg, BCNT_W bits: count of inserted bubbles.

Function
REQ-017 The module SHALL define up = stall[STAGE] and dn = stall[STAGE+1], evaluated every cycle.
REQ-018 The module SHALL apply the following priority on each rising edge: rst, then flush, then bubble, then advance, then hold.
REQ-019 On flush=1, the module SHALL set out_payload to NOP_VAL and out_temp/out_cnt to 0, regardless of stall; out_bcnt is unchanged.
REQ-020 On bubble (up=Stop, dn=NoStop, no flush), the module SHALL set out_payload to NOP_VAL, capture out_temp<=in_temp and out_cnt<=in_cnt, and increment out_bcnt.
REQ-021 On advance (up=NoStop, no flush), the module SHALL set out_payload<=in_payload and out_temp/out_cnt to 0; dn is ignored.
REQ-022 On hold (up=Stop, dn=Stop, no flush), the module SHALL keep out_payload unchanged and still capture out_temp<=in_temp and out_cnt<=in_cnt.
REQ-023 Payload latency SHALL be exactly one clock from in_payload to out_payload when advancing; scratch feedback latency SHALL be exactly one clock.
REQ-024 out_bcnt SHALL saturate at all-ones and not wrap.
REQ-025 bcnt_clr=1 SHALL set out_bcnt to 0 and take precedence over a simultaneous bubble increment; it SHALL NOT affect the other outputs.
REQ-026 The module SHALL contain no combinational path from inputs to outputs.
REQ-027 STAGE outside 0..4 SHALL be a configuration error: simulation stops with a fatal message at time 0.

Reset
REQ-028 With rst=1 at a rising edge, the module SHALL set out_payload to NOP_VAL and out_temp, out_cnt and out_bcnt to 0, overriding flush, stall and bcnt_clr.
REQ-029 After reset deasserts, the first edge SHALL follow REQ-018 normally; rst asserted mid-multi-cycle operation SHALL discard the captured scratch.

Verification
REQ-030 Advance: stall=0, in_payload=0x1_2345_6789_ABCD_..., in_temp=0xFF -> after 1 edge out_payload equals in_payload, out_temp=0, out_cnt=0.
REQ-031 Bubble: STAGE=3, stall=6'b001111, in_temp=0x0000_0001_0000_0002, in_cnt=1 -> out_payload=NOP_VAL, out_temp=0x0000_0001_0000_0002, out_cnt=1, out_bcnt increments 0->1.
REQ-032 Hold: load payload P, then stall=6'b011111 for 3 edges with in_cnt stepping 1,2,3 -> out_payload stays P, out_cnt tracks 1,2,3, out_bcnt unchanged.
REQ-033 Flush priority: stall=6'b001111 with flush=1 -> out_payload=NOP_VAL, out_temp=0, out_cnt=0, out_bcnt unchanged.
REQ-034 Saturation and clear: BCNT_W=2, five bubble cycles -> out_bcnt reads 1,2,3,3,3; bcnt_clr=1 together with a bubble -> out_bcnt=0.
REQ-035 Reset mid-operation: during hold with out_temp nonzero, rst=1 for one edge -> all outputs at reset values; next edge with stall=0 advances normally.
